// File: rtl/pdm_dac_stereo.sv
// Stereo first-order sigma-delta PDM DAC with a one-deep staging buffer and an
// internal sample-rate tick that moves each staged pair into the active register.
module pdm_dac_stereo #(
  parameter int DW   = 16,
  parameter int RATE = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_l,
  input  logic [DW-1:0] in_r,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mute,
  output logic          tick,
  output logic [7:0]    underrun,
  output logic          pdm_l,
  output logic          pdm_r
);

  localparam int CW = $clog2(RATE);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATE - 1);
  localparam logic [DW-1:0] MID      = {1'b1, {(DW-1){1'b0}}};

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            stage_full_q, stage_full_d;
  logic [2*DW-1:0] stage_q, stage_d;
  logic [2*DW-1:0] active_q, active_d;
  logic [7:0]      underrun_q, underrun_d;
  logic            tick_q, tick_d;
  logic [DW:0]     acc_l_q, acc_l_d;
  logic [DW:0]     acc_r_q, acc_r_d;
  logic            pdm_l_q, pdm_l_d;
  logic            pdm_r_q, pdm_r_d;

  logic            tick_i;
  logic            accept;
  logic [DW-1:0]   u_l, u_r;

  always_comb begin
    tick_i   = (cnt_q == CNT_LAST);
    in_ready = ~stage_full_q | tick_i;
    accept   = in_valid & in_ready;

    cnt_d        = tick_i ? '0 : cnt_q + CW'(1);
    stage_d      = accept ? {in_l, in_r} : stage_q;
    // A tick empties the stage, but an accept in the same cycle refills it.
    stage_full_d = tick_i ? accept : (stage_full_q | accept);
    active_d     = (tick_i && stage_full_q) ? stage_q : active_q;
    tick_d       = tick_i;

    underrun_d = underrun_q;
    if (tick_i && !stage_full_q && (underrun_q != 8'hFF)) begin
      underrun_d = underrun_q + 8'd1;
    end

    // Signed samples become offset binary so the accumulator adds a plain unsigned level.
    u_l = mute ? MID : {~active_q[2*DW-1], active_q[2*DW-2:DW]};
    u_r = mute ? MID : {~active_q[DW-1], active_q[DW-2:0]};

    acc_l_d = {1'b0, acc_l_q[DW-1:0]} + {1'b0, u_l};
    acc_r_d = {1'b0, acc_r_q[DW-1:0]} + {1'b0, u_r};
    pdm_l_d = acc_l_q[DW];
    pdm_r_d = acc_r_q[DW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      stage_full_q <= 1'b0;
      stage_q      <= '0;
      active_q     <= '0;
      underrun_q   <= '0;
      tick_q       <= 1'b0;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
      pdm_l_q      <= 1'b0;
      pdm_r_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stage_full_q <= stage_full_d;
      stage_q      <= stage_d;
      active_q     <= active_d;
      underrun_q   <= underrun_d;
      tick_q       <= tick_d;
      acc_l_q      <= acc_l_d;
      acc_r_q      <= acc_r_d;
      pdm_l_q      <= pdm_l_d;
      pdm_r_q      <= pdm_r_d;
    end
  end

  assign tick     = tick_q;
  assign underrun = underrun_q;
  assign pdm_l    = pdm_l_q;
  assign pdm_r    = pdm_r_q;

endmodule

// File: tb/tb_pdm_dac_stereo.sv
// Scoreboarded bench for pdm_dac_stereo: directed stimulus pushes cycle-stamped
// expectations, and a negedge monitor pops and compares them against the DUT.
module tb_pdm_dac_stereo;

  localparam int DW   = 16;
  localparam int RATE = 16;
  localparam int CMAX = 16384;

  localparam int K_PDML  = 0;
  localparam int K_PDMR  = 1;
  localparam int K_RDY   = 2;
  localparam int K_UND   = 3;
  localparam int K_TICK  = 4;
  localparam int K_ONESL = 5;
  localparam int K_ONESR = 6;

  typedef struct {
    int    cyc;
    int    start;
    int    kind;
    int    expv;
    int    tol;
    string name;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_l = '0;
  logic [DW-1:0] in_r = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mute = 1'b0;
  logic          tick;
  logic [7:0]    underrun;
  logic          pdm_l;
  logic          pdm_r;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cum_l [0:CMAX-1];
  int   cum_r [0:CMAX-1];
  exp_t exp_q [$];

  pdm_dac_stereo #(.DW(DW), .RATE(RATE)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_l     (in_l),
    .in_r     (in_r),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mute     (mute),
    .tick     (tick),
    .underrun (underrun),
    .pdm_l    (pdm_l),
    .pdm_r    (pdm_r)
  );

  always #5 clk = ~clk;

  // cyc is the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int c, input int s, input int k, input int v,
                          input int t, input string n);
    exp_t e;
    int   pos;
    e.cyc = c; e.start = s; e.kind = k; e.expv = v; e.tol = t; e.name = n;
    pos = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc > c) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, e);
  endtask

  task automatic expect_at(input int c, input int k, input int v, input string n);
    push_exp(c, 0, k, v, 0, n);
  endtask

  task automatic expect_ones(input int s, input int c, input int k, input int v,
                             input int t, input string n);
    push_exp(c, s, k, v, t, n);
  endtask

  function automatic int clamp_idx(input int c);
    if (c < 0) return 0;
    if (c >= CMAX) return CMAX - 1;
    return c;
  endfunction

  task automatic check_output(input exp_t e, input int now);
    int act;
    int diff;
    case (e.kind)
      K_PDML:  act = int'(pdm_l);
      K_PDMR:  act = int'(pdm_r);
      K_RDY:   act = int'(in_ready);
      K_UND:   act = int'(underrun);
      K_TICK:  act = int'(tick);
      K_ONESL: act = cum_l[clamp_idx(e.cyc)] - cum_l[clamp_idx(e.start)];
      default: act = cum_r[clamp_idx(e.cyc)] - cum_r[clamp_idx(e.start)];
    endcase
    diff = act - e.expv;
    if (diff < 0) diff = -diff;
    n_checks++;
    if (e.cyc != now) begin
      $display("[TB] FAIL %s: check due at cycle %0d missed (now %0d), got %0d, expected %0d",
               e.name, e.cyc, now, act, e.expv);
    end else if (diff > e.tol) begin
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d (+/-%0d)",
               e.name, now, act, e.expv, e.tol);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: accumulate pdm ones, then retire every expectation due this cycle.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < CMAX) begin
      cum_l[cyc] = cum_l[cyc-1] + int'(pdm_l);
      cum_r[cyc] = cum_r[cyc-1] + int'(pdm_r);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      check_output(exp_q[0], cyc);
      void'(exp_q.pop_front());
    end
  end

  task automatic apply_stimulus(input logic [DW-1:0] l, input logic [DW-1:0] r,
                                input logic v);
    in_l     = l;
    in_r     = r;
    in_valid = v;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(output int r);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    r = cyc;
  endtask

  initial begin
    int r;
    int r2;
    int m;
    int m2;
    int x;
    int a;
    int pat [6];
    pat = '{0, 0, 1, 0, 1, 0};
    cum_l[0] = 0;
    cum_r[0] = 0;

    // Idle after reset: mid-scale pattern, underrun climbs once per RATE and saturates.
    do_reset(r);
    expect_at(r, K_PDML, 0, "t1_rst_pdml");
    expect_at(r, K_PDMR, 0, "t1_rst_pdmr");
    expect_at(r, K_UND, 0, "t1_rst_und");
    expect_at(r, K_TICK, 0, "t1_rst_tick");
    expect_at(r, K_RDY, 1, "t1_rst_rdy");
    for (int k = 1; k <= 6; k++) begin
      expect_at(r + k, K_PDML, pat[k-1], $sformatf("t1_pdml_c%0d", k));
      expect_at(r + k, K_PDMR, pat[k-1], $sformatf("t1_pdmr_c%0d", k));
    end
    expect_ones(r + 3, r + 103, K_ONESL, 50, 0, "t1_ones_l");
    expect_at(r + RATE - 1, K_UND, 0, "t1_und_pre");
    expect_at(r + RATE - 1, K_TICK, 0, "t1_tick_pre");
    expect_at(r + RATE, K_UND, 1, "t1_und_1");
    expect_at(r + RATE, K_TICK, 1, "t1_tick_1");
    expect_at(r + 2*RATE, K_UND, 2, "t1_und_2");
    expect_at(r + 255*RATE - 1, K_UND, 254, "t1_und_254");
    expect_at(r + 255*RATE, K_UND, 255, "t1_und_255");
    expect_at(r + 256*RATE + 1, K_UND, 255, "t1_und_sat");
    wait_until(r + 256*RATE + 2);

    // Full-scale positive left, full-scale negative right.
    do_reset(r);
    apply_stimulus(16'h7FFF, 16'h8000, 1'b1);
    expect_at(r, K_UND, 0, "t2_und_cleared");
    expect_at(r, K_RDY, 1, "t2_rdy_empty");
    expect_at(r + 2, K_RDY, 0, "t2_rdy_low_a");
    expect_at(r + RATE - 2, K_RDY, 0, "t2_rdy_low_b");
    expect_at(r + RATE - 1, K_RDY, 1, "t2_rdy_tick");
    expect_at(r + RATE, K_RDY, 0, "t2_rdy_after");
    expect_at(r + RATE, K_TICK, 1, "t2_tick");
    expect_at(r + RATE, K_UND, 0, "t2_und");
    expect_at(r + RATE + 1, K_PDMR, 1, "t2_pdmr_last1");
    expect_at(r + RATE + 2, K_PDMR, 0, "t2_pdmr_zero");
    expect_at(r + RATE + 2, K_PDML, 0, "t2_pdml_first");
    expect_ones(r + RATE + 2, r + RATE + 1002, K_ONESL, 1000, 0, "t2_ones_l");
    expect_ones(r + RATE + 1, r + RATE + 1001, K_ONESR, 0, 0, "t2_ones_r");
    wait_until(r + RATE + 1003);

    // Back-to-back pairs: the new pair is staged on the same edge the old one goes active.
    do_reset(r);
    apply_stimulus(16'h8000, 16'h0000, 1'b1);
    expect_at(r + RATE - 1, K_RDY, 1, "t3_rdy_tick1");
    expect_at(r + RATE, K_RDY, 0, "t3_rdy_after1");
    expect_at(r + RATE, K_TICK, 1, "t3_tick1");
    expect_at(r + RATE, K_UND, 0, "t3_und1");
    expect_at(r + RATE + 5, K_RDY, 0, "t3_rdy_mid");
    expect_ones(r + RATE + 1, r + 2*RATE + 2, K_ONESL, 0, 0, "t3_ones_a");
    expect_at(r + 2*RATE - 1, K_RDY, 1, "t3_rdy_tick2");
    expect_at(r + 2*RATE, K_UND, 0, "t3_und2");
    expect_at(r + 2*RATE + 3, K_PDML, 1, "t3_pdml_b");
    expect_ones(r + 2*RATE + 2, r + 3*RATE + 1, K_ONESL, RATE - 1, 0, "t3_ones_b");
    expect_at(r + 3*RATE, K_UND, 0, "t3_und3");
    expect_ones(r + 3*RATE + 1, r + 3*RATE + 11, K_ONESL, 0, 0, "t3_ones_c");
    wait_until(r + 1);
    apply_stimulus(16'h7FFF, 16'h1234, 1'b1);
    wait_until(r + RATE);
    apply_stimulus(16'h8000, 16'h1234, 1'b1);
    wait_until(r + 3*RATE + 12);

    // Quarter-scale levels: 75% and 25% duty.
    do_reset(r);
    apply_stimulus(16'h4000, 16'hC000, 1'b1);
    a = r + RATE + 2;
    expect_ones(a, a + 4096, K_ONESL, 3072, 1, "t4_ones_l");
    expect_ones(a, a + 4096, K_ONESR, 1024, 1, "t4_ones_r");
    wait_until(a + 4097);

    // Mute forces 50% duty without stalling the handshake.
    do_reset(r);
    apply_stimulus(16'h7FFF, 16'h7FFF, 1'b1);
    m  = r + RATE + 4;
    m2 = m + 120;
    expect_ones(m + 1, m + 101, K_ONESL, 50, 0, "t5_mute_l");
    expect_ones(m + 1, m + 101, K_ONESR, 50, 0, "t5_mute_r");
    expect_at(r + 2*RATE - 1, K_RDY, 1, "t5_rdy_tick");
    expect_at(r + 2*RATE, K_TICK, 1, "t5_tick");
    expect_at(r + 2*RATE, K_UND, 0, "t5_und");
    expect_ones(m2 + 1, m2 + 201, K_ONESL, 200, 1, "t5_unmute_l");
    wait_until(m);
    mute = 1'b1;
    wait_until(m2);
    mute = 1'b0;
    wait_until(m2 + 202);

    // Reset mid-stream with the stage full discards both staged and active pairs.
    do_reset(r);
    apply_stimulus(16'h7FFF, 16'h7FFF, 1'b1);
    x = r + 2*RATE + 5;
    expect_at(r + 2*RATE, K_UND, 1, "t6_und_pre");
    expect_at(r + 2*RATE, K_TICK, 1, "t6_tick_pre");
    expect_at(x, K_RDY, 0, "t6_rdy_full");
    expect_at(x, K_PDML, 1, "t6_pdml_pre");
    wait_until(r + 1);
    apply_stimulus(16'h7FFF, 16'h7FFF, 1'b0);
    wait_until(r + 2*RATE + 1);
    apply_stimulus(16'h7FFF, 16'h8000, 1'b1);
    wait_until(r + 2*RATE + 2);
    apply_stimulus(16'h7FFF, 16'h8000, 1'b0);
    wait_until(x);
    do_reset(r2);
    expect_at(r2, K_PDML, 0, "t6_rst_pdml");
    expect_at(r2, K_PDMR, 0, "t6_rst_pdmr");
    expect_at(r2, K_UND, 0, "t6_rst_und");
    expect_at(r2, K_TICK, 0, "t6_rst_tick");
    expect_at(r2, K_RDY, 1, "t6_rst_rdy");
    expect_at(r2 + 3, K_PDML, 1, "t6_pdml_mid");
    expect_at(r2 + RATE - 1, K_TICK, 0, "t6_tick_early");
    expect_at(r2 + RATE, K_TICK, 1, "t6_tick_first");
    expect_at(r2 + RATE, K_UND, 1, "t6_und_discard");
    wait_until(r2 + RATE + 2);

    repeat (4) @(posedge clk);
    while (exp_q.size() > 0) begin
      n_checks++;
      $display("[TB] FAIL %s: check due at cycle %0d never reached, got none, expected %0d",
               exp_q[0].name, exp_q[0].cyc, exp_q[0].expv);
      void'(exp_q.pop_front());
    end
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
